// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared shifter op codes and iterative-shifter state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package shift_pkg;

    // Datapath shifter op encoding, shared with the ALU shifter
    localparam logic [1:0] SH_PASS = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    // Iterative shifter control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/iter_shifter_step.sv
`default_nettype none
// ============================================================================
//  Module      : iter_shifter_step
//  Description : Combinational single-position shifter (pass/LSL/LSR/ASR).
//  Revision    : 1.0  initial release
// ============================================================================
module iter_shifter_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    output logic [WIDTH-1:0] sout
);

    // Apply one shift step selected by the op code
    always_comb begin
        sout = in;
        case (shift)
            SH_PASS: sout = in;
            SH_LSL:  sout = {in[WIDTH-2:0], 1'b0};
            SH_LSR:  sout = {1'b0, in[WIDTH-1:1]};
            SH_ASR:  sout = {in[WIDTH-1], in[WIDTH-1:1]};
            default: sout = in;
        endcase
    end

endmodule : iter_shifter_step
`default_nettype wire

// File: rtl/iter_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : iter_shifter
//  Description : Multi-cycle shift engine, one bit position per clock.
//                start captures operand/op/amount; done pulses for one cycle
//                with the result on sout, which holds until the next done.
//  Revision    : 1.0  initial release
// ============================================================================
module iter_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sout
);

    localparam logic [AMT_W-1:0] C_CNT_ONE = AMT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [1:0]       op_q,    op_d;
    logic [AMT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] sout_q,  sout_d;
    logic [WIDTH-1:0] step_w;

    // Step function: the accumulator shifted one position by the captured op
    iter_shifter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .in    (acc_q),
        .shift (op_q),
        .sout  (step_w)
    );

    // Next-state, datapath updates and result capture on entry to DONE
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = in;
                    op_d  = op;
                    cnt_d = amt;
                    // Nothing to iterate: the operand is already the result
                    if ((amt == '0) || (op == SH_PASS)) begin
                        state_d = DONE;
                        sout_d  = in;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = step_w;
                cnt_d = cnt_q - C_CNT_ONE;
                // Last step: publish the final shifted value as we enter DONE
                if (cnt_q == C_CNT_ONE) begin
                    state_d = DONE;
                    sout_d  = step_w;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= SH_PASS;
            cnt_q   <= '0;
            sout_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sout = sout_q;

endmodule : iter_shifter
`default_nettype wire

// File: tb/tb_iter_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iter_shifter
//  Description : Directed self-checking bench for iter_shifter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_iter_shifter;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] in_v;
    logic [1:0]  op;
    logic [3:0]  amt;
    logic        busy;
    logic        done;
    logic [15:0] sout;

    int n_chk  = 0;
    int n_fail = 0;

    iter_shifter #(
        .WIDTH (16),
        .AMT_W (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in    (in_v),
        .op    (op),
        .amt   (amt),
        .busy  (busy),
        .done  (done),
        .sout  (sout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, measure cycles from the accepting edge to done,
    // and optionally poke start with different operands while busy.
    task automatic run(input string tag, input logic [15:0] x, input logic [1:0] o,
                       input logic [3:0] a, input logic [15:0] exp_sout,
                       input int exp_lat, input bit poke);
        int cyc;
        cyc   = 0;
        start = 1'b1;
        in_v  = x;
        op    = o;
        amt   = a;
        tick();
        start = 1'b0;
        in_v  = 16'h5A5A;
        while (done !== 1'b1 && cyc < 40) begin
            if (poke && cyc == 1) begin
                start = 1'b1;
                in_v  = 16'hFFFF;
                op    = SH_LSR;
                amt   = 4'd1;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        check({tag, "_lat"},  cyc,  exp_lat);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_sout"}, sout, exp_sout);
        if (poke) begin
            start = 1'b1;
            in_v  = 16'h1234;
            op    = SH_LSL;
            amt   = 4'd3;
        end
        tick();
        start = 1'b0;
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_idle_done"}, done, 1'b0);
        check({tag, "_hold_sout"}, sout, exp_sout);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        in_v  = 16'hBEEF;
        op    = SH_LSL;
        amt   = 4'd3;
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sout", sout, 16'h0000);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("post_rst_busy", busy, 1'b0);

        run("lsl1",   16'b1111000011001111, SH_LSL,  4'd1,  16'b1110000110011110, 1,  1'b0);
        run("lsr4",   16'b1111000011001111, SH_LSR,  4'd4,  16'b0000111100001100, 4,  1'b0);
        run("asr4",   16'b1111000011001111, SH_ASR,  4'd4,  16'b1111111100001100, 4,  1'b0);
        run("lsl15",  16'h0001,             SH_LSL,  4'd15, 16'h8000,             15, 1'b0);
        run("lsr15",  16'h8000,             SH_LSR,  4'd15, 16'h0001,             15, 1'b0);
        run("asr15n", 16'h8000,             SH_ASR,  4'd15, 16'hFFFF,             15, 1'b0);
        run("asr15p", 16'h7FFF,             SH_ASR,  4'd15, 16'h0000,             15, 1'b0);
        run("amt0",   16'hABCD,             SH_LSL,  4'd0,  16'hABCD,             0,  1'b0);
        run("pass9",  16'h1234,             SH_PASS, 4'd9,  16'h1234,             0,  1'b0);
        run("poke",   16'h00FF,             SH_LSL,  4'd8,  16'hFF00,             8,  1'b1);

        // Abort mid-SHIFT: no completion may follow, result clears
        start = 1'b1;
        in_v  = 16'h0F0F;
        op    = SH_LSL;
        amt   = 4'd8;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_busy_pre", busy, 1'b1);
        check("abort_sout_pre", sout, 16'hFF00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_sout", sout, 16'h0000);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                if (done === 1'b1 || busy === 1'b1) seen++;
                tick();
            end
            check("abort_quiet", seen, 0);
        end
        run("after_abort", 16'h0F0F, SH_LSR, 4'd2, 16'h03C3, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_iter_shifter
`default_nettype wire
